// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: single-cycle hits, one 256-bit line fill per miss.
// Supports flush (fence.i) and provides saturating hit/miss counters.
module icache_responder #(
    parameter int NUM_SETS   = 8,
    parameter int LINE_BYTES = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         imem_read,
    input  logic [31:0]  imem_addr,
    output logic         imem_resp,
    output logic [31:0]  imem_data,
    input  logic         flush,
    output logic         pmem_read,
    output logic [31:0]  pmem_addr,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata,
    output logic [31:0]  perf_hits,
    output logic [31:0]  perf_misses
);

    localparam int OFFSET_W = $clog2(LINE_BYTES);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic                resp_q, resp_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                pmem_read_q, pmem_read_d;
    logic [31:0]         pmem_addr_q, pmem_addr_d;
    logic [31:0]         hits_q, hits_d;
    logic [31:0]         misses_q, misses_d;
    logic [31:2]         miss_addr_q, miss_addr_d;
    logic [31:0]         fill_word_q, fill_word_d;
    logic                flushed_q, flushed_d;

    logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
    logic [255:0]        data_arr [NUM_SETS];

    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [2:0]          req_word;
    logic [INDEX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [255:0]        line_rd;
    logic                hit;
    logic                install_en;
    logic                unused_addr_lsb;

    assign req_idx         = imem_addr[OFFSET_W +: INDEX_W];
    assign req_tag         = imem_addr[31 -: TAG_W];
    assign req_word        = imem_addr[4:2];
    assign fill_idx        = miss_addr_q[OFFSET_W +: INDEX_W];
    assign fill_tag        = miss_addr_q[31 -: TAG_W];
    assign line_rd         = data_arr[req_idx];
    assign hit             = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign unused_addr_lsb = ^imem_addr[1:0];

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        resp_d      = 1'b0;
        rdata_d     = rdata_q;
        pmem_read_d = pmem_read_q;
        pmem_addr_d = pmem_addr_q;
        hits_d      = hits_q;
        misses_d    = misses_q;
        miss_addr_d = miss_addr_q;
        fill_word_d = fill_word_q;
        flushed_d   = flushed_q;
        install_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) valid_d = '0;
                // A request still high in the response cycle is the one just answered.
                if (imem_read && !resp_q) begin
                    if (hit && !flush) begin
                        resp_d  = 1'b1;
                        rdata_d = line_rd[{req_word, 5'b0} +: 32];
                        hits_d  = (hits_q == '1) ? hits_q : hits_q + 32'd1;
                    end else begin
                        state_d     = FILL;
                        pmem_read_d = 1'b1;
                        pmem_addr_d = {imem_addr[31:5], 5'b0};
                        misses_d    = (misses_q == '1) ? misses_q : misses_q + 32'd1;
                        miss_addr_d = imem_addr[31:2];
                        flushed_d   = 1'b0;
                    end
                end
            end
            FILL: begin
                if (flush) begin
                    valid_d   = '0;
                    flushed_d = 1'b1;
                end
                if (pmem_resp) begin
                    // A flush seen at any point during the fill leaves the new line invalid.
                    install_en        = 1'b1;
                    valid_d[fill_idx] = !(flushed_q || flush);
                    pmem_read_d       = 1'b0;
                    fill_word_d       = pmem_rdata[{miss_addr_q[4:2], 5'b0} +: 32];
                    state_d           = RESP;
                end
            end
            RESP: begin
                if (flush) valid_d = '0;
                if (imem_read && (imem_addr[31:5] == miss_addr_q[31:5])) begin
                    resp_d  = 1'b1;
                    rdata_d = fill_word_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            resp_q      <= 1'b0;
            rdata_q     <= '0;
            pmem_read_q <= 1'b0;
            pmem_addr_q <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
            miss_addr_q <= '0;
            fill_word_q <= '0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
            pmem_read_q <= pmem_read_d;
            pmem_addr_q <= pmem_addr_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
            miss_addr_q <= miss_addr_d;
            fill_word_q <= fill_word_d;
            flushed_q   <= flushed_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (install_en) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= pmem_rdata;
        end
    end

    assign imem_resp   = resp_q;
    assign imem_data   = rdata_q;
    assign pmem_read   = pmem_read_q;
    assign pmem_addr   = pmem_addr_q;
    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: a pmem responder, a response scoreboard and
// an independent memory-content model drive and check each access.
module tb_icache_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         imem_read;
    logic [31:0]  imem_addr;
    logic         imem_resp;
    logic [31:0]  imem_data;
    logic         flush;
    logic         pmem_read;
    logic [31:0]  pmem_addr;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic [31:0]  perf_hits;
    logic [31:0]  perf_misses;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned exp_hits   = 0;
    int unsigned exp_misses = 0;
    int unsigned fill_no    = 0;
    logic [31:0] sb [$];
    logic [7:0]  last_salt [logic [31:0]];
    logic        prev_resp = 1'b0;

    icache_responder #(.NUM_SETS(8), .LINE_BYTES(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_read   (imem_read),
        .imem_addr   (imem_addr),
        .imem_resp   (imem_resp),
        .imem_data   (imem_data),
        .flush       (flush),
        .pmem_read   (pmem_read),
        .pmem_addr   (pmem_addr),
        .pmem_resp   (pmem_resp),
        .pmem_rdata  (pmem_rdata),
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
    );

    always #5 clk = ~clk;

    // Memory content: line 0x60 word 0 with salt 0 is 0x00000013.
    function automatic logic [31:0] mem_word(input logic [31:0] la, input int unsigned w, input logic [7:0] salt);
        logic [31:0] v;
        v = 32'h13 + (w << 8) + ((la ^ 32'h60) << 12);
        return v ^ {salt, 24'h0};
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la, input logic [7:0] salt);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(la, w, salt);
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && imem_resp === 1'b1) begin
            check("resp_gap", {31'b0, prev_resp}, 32'd0);
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL unexpected_resp observed data=%h expected no response", imem_data);
            end else begin
                check("resp_data", imem_data, sb.pop_front());
            end
        end
        prev_resp = (imem_resp === 1'b1);
    end

    task automatic access(input logic [31:0] addr, input bit miss, input int dly,
                          input bit drop, input bit flush_mid, input bit flush_req);
        logic [31:0]  la;
        logic [7:0]   salt;
        logic [31:0]  expw;
        la = addr & ~32'h1F;
        imem_read = 1'b1;
        imem_addr = addr;
        if (!miss) begin
            expw = mem_word(la, addr[4:2], last_salt[la]);
            sb.push_back(expw);
            exp_hits++;
            @(posedge clk); #1;
            check("hit_resp", {31'b0, imem_resp}, 32'd1);
            check("hit_no_pmem", {31'b0, pmem_read}, 32'd0);
            imem_read = 1'b0;
            @(posedge clk); #1;
            check("hit_pulse_end", {31'b0, imem_resp}, 32'd0);
            check("data_hold", imem_data, expw);
        end else begin
            salt = fill_no[7:0];
            fill_no++;
            last_salt[la] = salt;
            exp_misses++;
            flush = flush_req;
            @(posedge clk); #1;
            flush = 1'b0;
            check("miss_pmem_read", {31'b0, pmem_read}, 32'd1);
            check("miss_pmem_addr", pmem_addr, la);
            check("miss_no_resp", {31'b0, imem_resp}, 32'd0);
            for (int i = 0; i < dly; i++) begin
                if (flush_mid) flush = (i == 0);
                @(posedge clk); #1;
                check("fill_held", {pmem_addr[31:1], pmem_read}, {la[31:1], 1'b1});
            end
            flush = 1'b0;
            if (drop) imem_read = 1'b0;
            else sb.push_back(mem_word(la, addr[4:2], salt));
            pmem_resp  = 1'b1;
            pmem_rdata = mem_line(la, salt);
            @(posedge clk); #1;
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            check("fill_read_drop", {31'b0, pmem_read}, 32'd0);
            check("resp_cycle_quiet", {31'b0, imem_resp}, 32'd0);
            @(posedge clk); #1;
            check("miss_resp", {31'b0, imem_resp}, {31'b0, !drop});
            imem_read = 1'b0;
            @(posedge clk); #1;
            check("miss_pulse_end", {31'b0, imem_resp}, 32'd0);
        end
        check("perf_hits", perf_hits, exp_hits);
        check("perf_misses", perf_misses, exp_misses);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        imem_read  = 1'b0;
        imem_addr  = '0;
        flush      = 1'b0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #12;
        check("rst_resp", {31'b0, imem_resp}, 32'd0);
        check("rst_data", imem_data, 32'd0);
        check("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
        check("rst_pmem_addr", pmem_addr, 32'd0);
        check("rst_hits", perf_hits, 32'd0);
        check("rst_misses", perf_misses, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(32'h60,  1, 3, 0, 0, 0);   // cold miss, word0 = 0x13
        access(32'h64,  0, 0, 0, 0, 0);   // hit word1
        access(32'h160, 1, 1, 0, 0, 0);   // conflict eviction
        access(32'h60,  1, 2, 0, 0, 0);   // re-miss after eviction
        access(32'h7C,  0, 0, 0, 0, 0);   // hit last word

        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        access(32'h60,  1, 0, 0, 0, 0);   // miss after idle flush, zero-wait fill
        access(32'h68,  0, 0, 0, 0, 0);   // hit returns refreshed data

        access(32'h260, 1, 3, 0, 1, 0);   // flush mid-fill: response still delivered
        access(32'h260, 1, 1, 0, 0, 0);   // line installed invalid
        access(32'h268, 0, 0, 0, 0, 0);
        access(32'h260, 1, 1, 0, 0, 1);   // flush with lookup forces miss

        access(32'h80,  1, 2, 1, 0, 0);   // abandoned fill still installs
        access(32'h84,  0, 0, 0, 0, 0);

        imem_read = 1'b1;
        imem_addr = 32'hA0;
        @(posedge clk); #1;
        check("rmf_pmem_read", {31'b0, pmem_read}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rmf_pmem_read_clr", {31'b0, pmem_read}, 32'd0);
        check("rmf_resp_clr", {31'b0, imem_resp}, 32'd0);
        check("rmf_hits_clr", perf_hits, 32'd0);
        check("rmf_misses_clr", perf_misses, 32'd0);
        imem_read = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(32'h80,  1, 1, 0, 0, 0);   // valid bits cleared by reset
        access(32'h9C,  0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-side memory responder for the fetch stage. It accepts word requests on imem_read/imem_addr and answers with a single-cycle imem_resp pulse and imem_data.
- Direct-mapped, read-only cache. Misses are filled with one full-line read transaction on a 256-bit physical-memory port.
- Sits between the fetch stage and the arbiter/physical memory.
- Also provides a flush (fence.i) and hit/miss performance counters.

Parameters:
NUM_SETS, 8, number of lines; power of two, ≥2; INDEX_W = log2(NUM_SETS)
LINE_BYTES, 32, bytes per line; fixed at 32 to match the 256-bit pmem port; OFFSET_W = 5
TAG_W, 32-5-INDEX_W (24 at default), stored tag width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_read  in  1  fetch request; held with a stable address until imem_resp
imem_addr  in  32  byte address; bits [1:0] are ignored
imem_resp  out  1  one-cycle pulse: imem_data is valid
imem_data  out  32  returned instruction word, registered
flush  in  1  invalidates all lines
pmem_read  out  1  line-fill request; held until pmem_resp
pmem_addr  out  32  line-aligned fill address; [4:0]=0
pmem_resp  in  1  one-cycle pulse: pmem_rdata is valid
pmem_rdata  in  256  fill line; word w = bits [32w+31:32w]
perf_hits  out  32  saturating count of hit responses
perf_misses  out  32  saturating count of fills started

Behaviour:
- Address split: tag=[31:5+INDEX_W], index=[4+INDEX_W:5], word=[4:2].
- Storage per set: valid bit, TAG_W tag, 256-bit data.
- Reset (async, rst_n=0):
  - state=IDLE; all valid bits=0.
  - imem_resp=0, imem_data=0, pmem_read=0, pmem_addr=0, perf_hits=0, perf_misses=0.
  - Tag/data arrays are not reset.
  - Reset asserted mid-fill abandons the fill with no response and no install.
- States: IDLE, FILL, RESP.
- IDLE:
  - imem_read=1 and hit (valid && tag match): next edge registers imem_data=line word and sets imem_resp=1 for exactly one cycle. Hit latency is 1 cycle. perf_hits += 1. State stays IDLE.
  - imem_read=1 and miss: next edge enters FILL with pmem_read=1 and pmem_addr={imem_addr[31:5],5'b0}. perf_misses += 1. The requested address is latched internally.
  - imem_read=0: no action.
  - A request in the cycle where imem_resp=1 is ignored. The requester sees at most one response per request.
- FILL:
  - pmem_read and pmem_addr are held constant until pmem_resp.
  - On pmem_resp:
    - install the line: data, tag, valid=1;
    - pmem_read=0 at the next edge;
    - next state RESP.
- RESP:
  - If imem_read is still 1 and imem_addr matches the latched line: one-cycle imem_resp with the word from the filled line. perf_hits is not incremented.
  - If imem_read=0 or the address changed (abandoned by branch recovery): no imem_resp.
  - Next state IDLE.
  - Miss latency with an N-cycle pmem = N+2 cycles from request to imem_resp.
- imem_resp is never high in two consecutive cycles.
- imem_data holds its last value when imem_resp=0.
- Flush:
  - In IDLE or RESP: clears all valid bits at the next edge. A hit lookup in the same cycle as flush is treated as a miss.
  - During FILL: clears valid bits immediately. The in-flight line still installs its data/tag with valid=0, and the response (RESP) is still delivered.
- Eviction: a new line overwrites its set unconditionally. There is no writeback (read-only).
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- The pmem_rdata word for the response is taken directly from pmem_rdata in the fill cycle. There is no read-after-write through the array.

Test Plan:
- Cold miss: reset, imem_read with addr 0x60 → pmem_read=1, pmem_addr=0x60. Return a line after 3 cycles with word0=0x00000013 → imem_resp 1 cycle later, imem_data=0x00000013, perf_misses=1.
- Hit: then read 0x64 → imem_resp on the next cycle with word1 of that line, no pmem_read, perf_hits=1, one-cycle pulse.
- Conflict: NUM_SETS=8, read 0x60, then 0x160 (same index, different tag) → second access misses with pmem_addr=0x160. Re-reading 0x60 misses again; perf_misses=3.
- Flush: after filling 0x60, pulse flush, read 0x60 → miss with fill issued. Flush mid-FILL → response delivered, but the next read of the same line misses.
- Abandon: miss on 0x80, drop imem_read during FILL → fill completes and installs, no imem_resp. A later read of 0x84 hits in 1 cycle.
- Reset mid-fill: assert rst_n=0 while pmem_read=1 → pmem_read, imem_resp, and counters go to 0 immediately. After release, read 0x80 misses.
